// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide sequencer: shift-add multiplier and restoring divider, one bit per cycle.
// Optional MDU_FAST_ZERO_EN skips the iteration phase when an operand makes the result trivial.
module mdu_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             kill,
    input  logic [2:0]       Funct3,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             ready,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   ONES_W   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]      CNT_LOAD = CW'(WIDTH-1);
    localparam logic [CW-1:0]      CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]      CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_ready;
    logic                 r_busy;
    logic                 r_done;
    logic [2:0]           r_f3;
    logic [WIDTH-1:0]     r_src_a;
    logic [WIDTH-1:0]     r_mag_a;
    logic [WIDTH-1:0]     r_mag_b;
    logic                 r_sign_a;
    logic                 r_sign_b;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CW-1:0]        r_cnt;
    logic [WIDTH-1:0]     r_result;

    logic                 w_sign_a;
    logic                 w_sign_b;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_rem_sh;
    logic [WIDTH:0]       w_trial;
    logic [2*WIDTH-1:0]   w_div_next;
    logic [2*WIDTH-1:0]   w_prod;
    logic                 w_b_zero;
    logic [WIDTH-1:0]     w_fix_result;

    function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v, input logic neg);
        if (neg) begin
            return ~v + ONE_W;
        end else begin
            return v;
        end
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] v, input logic neg);
        if (neg) begin
            return ~v + ONE_2W;
        end else begin
            return v;
        end
    endfunction

    // MULHSU treats only rs1 as signed; unsigned ops never set a sign flag
    assign w_sign_a = SrcA[WIDTH-1] & ((Funct3 == 3'b001) | (Funct3 == 3'b010) |
                                       (Funct3 == 3'b100) | (Funct3 == 3'b110));
    assign w_sign_b = SrcB[WIDTH-1] & ((Funct3 == 3'b001) | (Funct3 == 3'b100) | (Funct3 == 3'b110));

    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mag_a};
    assign w_mul_next = r_mag_b[0] ? {w_mul_sum, r_acc[WIDTH-1:1]} : {1'b0, r_acc[2*WIDTH-1:1]};
    assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_mag_a[WIDTH-1]};
    assign w_trial    = w_rem_sh - {1'b0, r_mag_b};
    assign w_div_next = w_trial[WIDTH] ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                       : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    assign w_prod     = cond_neg_2w(r_acc, r_sign_a ^ r_sign_b);
    assign w_b_zero   = (r_mag_b == ZERO_W);

    assign ready  = r_ready;
    assign busy   = r_busy;
    assign done   = r_done;
    assign Result = r_result;
    assign stall  = (start & r_ready & ~kill) | r_busy;

`ifdef MDU_FAST_ZERO_EN
    logic w_fast_zero;
    assign w_fast_zero = w_b_zero | (~r_f3[2] & (r_mag_a == ZERO_W));
`endif

    // Result selection and sign correction applied in FIX
    always_comb begin
        w_fix_result = ZERO_W;
        if (!r_f3[2]) begin
            if (r_f3[1:0] == 2'b00) begin
                w_fix_result = w_prod[WIDTH-1:0];
            end else begin
                w_fix_result = w_prod[2*WIDTH-1:WIDTH];
            end
        end else if (w_b_zero) begin
            // Division by zero returns the raw dividend as remainder, not its magnitude
            if (r_f3[1]) begin
                w_fix_result = r_src_a;
            end else begin
                w_fix_result = ONES_W;
            end
        end else if (r_f3[1]) begin
            w_fix_result = cond_neg_w(r_acc[2*WIDTH-1:WIDTH], r_sign_a);
        end else begin
            w_fix_result = cond_neg_w(r_acc[WIDTH-1:0], r_sign_a ^ r_sign_b);
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start & ~kill) begin
                    w_next = S_PREP;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_PREP: begin
                if (kill) begin
                    w_next = S_IDLE;
                end else begin
`ifdef MDU_FAST_ZERO_EN
                    w_next = w_fast_zero ? S_FIX : S_ITER;
`else
                    w_next = S_ITER;
`endif
                end
            end
            S_ITER: begin
                if (kill) begin
                    w_next = S_IDLE;
                end else if (r_cnt == CNT_ZERO) begin
                    w_next = S_FIX;
                end else begin
                    w_next = S_ITER;
                end
            end
            S_FIX: begin
                if (kill) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register and registered status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next == S_IDLE);
            r_busy  <= (w_next != S_IDLE);
            r_done  <= (w_next == S_DONE);
        end
    end

    // Operand capture, iteration datapath and result register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_f3     <= 3'b000;
            r_src_a  <= ZERO_W;
            r_mag_a  <= ZERO_W;
            r_mag_b  <= ZERO_W;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_acc    <= {(2*WIDTH){1'b0}};
            r_cnt    <= CNT_ZERO;
            r_result <= ZERO_W;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_next == S_PREP) begin
                        r_f3     <= Funct3;
                        r_src_a  <= SrcA;
                        r_sign_a <= w_sign_a;
                        r_sign_b <= w_sign_b;
                        r_mag_a  <= cond_neg_w(SrcA, w_sign_a);
                        r_mag_b  <= cond_neg_w(SrcB, w_sign_b);
                    end
                end
                S_PREP: begin
                    r_acc <= {(2*WIDTH){1'b0}};
                    r_cnt <= CNT_LOAD;
                end
                S_ITER: begin
                    // Multiplier bits are consumed from rs2, dividend bits from rs1
                    if (r_f3[2]) begin
                        r_acc   <= w_div_next;
                        r_mag_a <= {r_mag_a[WIDTH-2:0], 1'b0};
                    end else begin
                        r_acc   <= w_mul_next;
                        r_mag_b <= {1'b0, r_mag_b[WIDTH-1:1]};
                    end
                    if (r_cnt != CNT_ZERO) begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                S_FIX: begin
                    if (!kill) begin
                        r_result <= w_fix_result;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Iterative multiply/divide sequencer for the RV32M extension, sitting beside the main ALU in the execute stage. It accepts one operation at a time over a start/ready handshake and runs a shift-add multiplier or a restoring divider for WIDTH iterations. While the operation runs it holds the pipeline stall, then pulses `done` with the result. The main ALU keeps single-cycle operations; this block owns only the M-extension funct3 space (Funct7 = 0000001).

## Interface
- `WIDTH`, 32, operand and result width; must be ≥ 4 and even.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a new operation; sampled only while `ready`=1.
- `kill`  in  1  synchronous abort from pipeline flush.
- `Funct3`  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `SrcA`  in  WIDTH  rs1 operand; multiplicand or dividend.
- `SrcB`  in  WIDTH  rs2 operand; multiplier or divisor.
- `ready`  out  1  high only in IDLE.
- `stall`  out  1  `(start & ready & ~kill) | busy`, combinational, to the hazard unit.
- `busy`  out  1  registered; high in every state except IDLE.
- `done`  out  1  one-cycle pulse; `Result` is valid in that cycle.
- `Result`  out  WIDTH  registered result; holds its value until the next accepted start.

## Operation
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE → PREP on `start & ~kill`. The block latches Funct3 and both operands.
  - Signed ops (MULH, MULHSU for SrcA only, DIV, REM): operands are converted to magnitudes and the sign flags are saved.
- PREP → ITER: clears the 2·WIDTH accumulator and loads the iteration counter with WIDTH-1.
- ITER: one step per cycle; the counter decrements.
  - Multiply: conditional add of the multiplicand at the accumulator's upper half, then shift right by 1.
  - Divide: shift the remainder left by 1, trial-subtract the divisor, restore when negative, shift the quotient bit in.
  - When the counter reaches 0, go to FIX.
- FIX: applies sign correction (two's-complement negate when required), selects the low/high half or the quotient/remainder, and registers `Result`. Next state is DONE.
- DONE: `done`=1 for one cycle, then return to IDLE.
- Divide by zero: quotient = all ones; remainder = SrcA. No trap.
- Signed overflow (DIV/REM, SrcA = 1 followed by WIDTH-1 zeros, SrcB = all ones): quotient = SrcA; remainder = 0.
- `start` while busy is ignored. No queuing.
- `kill` in any non-IDLE state: return to IDLE next cycle. No `done` pulse; `Result` is unchanged.
- `kill` and `start` in the same IDLE cycle: kill wins and nothing is accepted.
- Reset (any time, including mid-operation): state=IDLE, `busy`=0, `done`=0, `ready`=1, `Result`=0, counter and accumulator = 0.

## Timing
- Start accepted at edge E0. Then:
  - PREP occupies cycle 1.
  - ITER occupies cycles 2 .. WIDTH+1.
  - FIX occupies cycle WIDTH+2.
  - DONE occupies cycle WIDTH+3.
- Latency from start to `done` is WIDTH+3 cycles, which is 35 for WIDTH=32.
- `ready` returns high in the cycle after DONE, so back-to-back operations are spaced WIDTH+4 cycles apart.
- `stall` is high from the start cycle through the DONE cycle inclusive. The consuming stage captures `Result` in the DONE cycle.
- All outputs except `stall` are registered.

## Configuration
- `MDU_FAST_ZERO_EN` defined:
  - PREP detects SrcB = 0 (any op) or SrcA = 0 (multiply ops).
  - On detection it jumps to FIX, skipping ITER, with a latency of 3 cycles.
  - FIX produces the same architectural results as the full path.
- `MDU_FAST_ZERO_EN` undefined: every operation takes the full WIDTH+3 cycles.

## Test plan
- MUL, SrcA = 7, SrcB = 0xFFFFFFFD (−3) → `done` 35 cycles after start, `Result` = 0xFFFFFFEB.
- MULH, SrcA = SrcB = 0x80000000 → `Result` = 0x40000000. MULHU with the same operands → 0x40000000. MULHSU, SrcA = 0xFFFFFFFF, SrcB = 2 → 0xFFFFFFFF.
- DIV, SrcA = 0x80000000, SrcB = 0xFFFFFFFF → `Result` = 0x80000000. REM with the same operands → 0. DIV −7 / 2 → 0xFFFFFFFD. REM −7 / 2 → 0xFFFFFFFF.
- Divide by zero:
  - DIVU 0x1234 / 0 → 0xFFFFFFFF.
  - REMU 0x1234 / 0 → 0x1234.
  - With `MDU_FAST_ZERO_EN`, `done` arrives 3 cycles after start.
  - Without it, `done` arrives 35 cycles after start.
- `kill` asserted in ITER cycle 10 → IDLE next cycle, no `done`, `Result` keeps its prior value. A second `start` pulse during ITER is ignored.
- `reset` low mid-ITER → all outputs at reset values immediately. After release, a new MUL 3·5 returns 15 at latency 35.
